// File: rtl/prog_loader_if.sv
// Host-side word stream into the program loader: 8-bit words (opcode[7:4], operand[3:0])
// carried over a valid/ready handshake.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Buffers a host program, then bursts it into the 4-bit core's program memory
// while holding the core in reset, rewinds its PC and releases it to run.
module prog_loader #(
  parameter int         DEPTH    = 16,
  parameter int         ADDR_W   = 4,
  parameter logic [7:0] PAD_WORD = 8'h9F
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      host,
  input  logic              start,
  input  logic              reload,
  output logic              pc_reset,
  output logic              mem_write,
  output logic [3:0]        instr,
  output logic [3:0]        portin,
  output logic [ADDR_W:0]   word_cnt,
  output logic              running
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {FILL, BURST, REWIND, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]   emit_q, emit_d;
  logic              pc_reset_q, pc_reset_d;
  logic              mem_write_q, mem_write_d;
  logic [7:0]        word_q, word_d;
  logic              running_q, running_d;
  logic              in_ready_q, in_ready_d;

  logic [7:0]        buf_mem [DEPTH];

  logic              hs;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] slot;
  logic [ADDR_W:0]   cnt_eff;
  logic [7:0]        emit_word;

  assign hs      = host.in_valid & in_ready_q;
  assign wr_addr = word_cnt_q[ADDR_W-1:0];

  // Slot for the word leaving on the next cycle. The core PC steps once before
  // the first write, so emission starts at slot 1 and wraps to slot 0 last.
  always_comb begin
    slot      = emit_q[ADDR_W-1:0] + 1'b1;
    cnt_eff   = word_cnt_q + {{ADDR_W{1'b0}}, hs};
    emit_word = PAD_WORD;
    if (state_q == FILL) begin
      slot = ADDR_W'(1);
    end
    // Forward a word accepted on the same edge that start is sampled.
    if ({1'b0, slot} < cnt_eff) begin
      emit_word = (hs && (wr_addr == slot)) ? host.in_data : buf_mem[slot];
    end
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    emit_d      = emit_q;
    pc_reset_d  = 1'b1;
    mem_write_d = 1'b0;
    word_d      = 8'h00;
    running_d   = 1'b0;
    in_ready_d  = 1'b0;

    case (state_q)
      FILL: begin
        if (hs) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
        if (start) begin
          state_d     = BURST;
          emit_d      = (ADDR_W + 1)'(1);
          pc_reset_d  = 1'b0;
          mem_write_d = 1'b1;
          word_d      = emit_word;
        end else begin
          in_ready_d = (word_cnt_d < DEPTH_W);
        end
      end
      BURST: begin
        if (emit_q == DEPTH_W) begin
          state_d = REWIND;
        end else begin
          emit_d      = emit_q + 1'b1;
          pc_reset_d  = 1'b0;
          mem_write_d = 1'b1;
          word_d      = emit_word;
        end
      end
      REWIND: begin
        state_d    = RUN;
        pc_reset_d = 1'b0;
        running_d  = 1'b1;
      end
      RUN: begin
        if (reload) begin
          state_d    = FILL;
          word_cnt_d = '0;
          in_ready_d = 1'b1;
        end else begin
          pc_reset_d = 1'b0;
          running_d  = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      word_cnt_q  <= '0;
      emit_q      <= '0;
      pc_reset_q  <= 1'b1;
      mem_write_q <= 1'b0;
      word_q      <= 8'h00;
      running_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      emit_q      <= emit_d;
      pc_reset_q  <= pc_reset_d;
      mem_write_q <= mem_write_d;
      word_q      <= word_d;
      running_q   <= running_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Storage is left uncleared by reset; unfilled slots are padded on emission.
  always_ff @(posedge clk) begin
    if (hs) begin
      buf_mem[wr_addr] <= host.in_data;
    end
  end

  assign host.in_ready = in_ready_q;
  assign pc_reset      = pc_reset_q;
  assign mem_write     = mem_write_q;
  assign instr         = word_q[7:4];
  assign portin        = word_q[3:0];
  assign word_cnt      = word_cnt_q;
  assign running       = running_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader, with a model of the core's program
// memory filled the way the core sees the burst.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       reload;
  logic       pc_reset;
  logic       mem_write;
  logic [3:0] instr;
  logic [3:0] portin;
  logic [4:0] word_cnt;
  logic       running;

  prog_loader_if bus ();

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .host      (bus.slave),
    .start     (start),
    .reload    (reload),
    .pc_reset  (pc_reset),
    .mem_write (mem_write),
    .instr     (instr),
    .portin    (portin),
    .word_cnt  (word_cnt),
    .running   (running)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prog[$];
  logic [7:0] core_pm[16];
  int         core_pc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: models the core PC/PM and checks each emitted word against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (pc_reset === 1'b1) begin
      core_pc = 0;
    end else if (mem_write === 1'b1) begin
      core_pc = (core_pc + 1) % 16;
      core_pm[core_pc] = {instr, portin};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL burst_word act=%02h exp=none", {instr, portin});
      end else begin
        e = exp_q.pop_front();
        check("burst_word", {24'd0, instr, portin}, {24'd0, e});
      end
    end
  end

  function automatic logic [7:0] prog_at(input int a);
    return (a < prog.size()) ? prog[a] : 8'h9F;
  endfunction

  task automatic load_expect();
    for (int e = 0; e < 16; e++) exp_q.push_back(prog_at((e + 1) % 16));
  endtask

  task automatic push(input logic [7:0] w);
    int t = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout act=%0b exp=1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    prog.push_back(w);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic push_with_start(input logic [7:0] w);
    @(negedge clk);
    check("ready_before_start", {31'd0, bus.in_ready}, 32'd1);
    prog.push_back(w);
    load_expect();
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    start        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic start_burst();
    @(negedge clk);
    load_expect();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_burst(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("burst_mw", {30'd0, pc_reset, mem_write}, 32'b01);
    end
    @(negedge clk);
    check("rewind", {22'd0, pc_reset, mem_write, instr, portin}, {22'd0, 2'b10, 8'h00});
    @(negedge clk);
    check("run", {28'd0, running, pc_reset, mem_write, bus.in_ready}, 32'b1000);
    check("word_cnt_hold", {27'd0, word_cnt}, prog.size());
    check("scoreboard_empty", exp_q.size(), 0);
    for (int a = 0; a < 16; a++) check("core_pm", {24'd0, core_pm[a]}, {24'd0, prog_at(a)});
    $display("load %s words=%0d checks=%0d failures=%0d", tag, prog.size(), checks, failures);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    prog.delete();
    @(negedge clk);
    check("reload_state", {24'd0, pc_reset, word_cnt, bus.in_ready, running},
          {24'd0, 1'b1, 5'd0, 1'b1, 1'b0});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", {20'd0, pc_reset, mem_write, instr, portin, word_cnt, bus.in_ready, running},
          {20'd0, 1'b1, 1'b0, 4'h0, 4'h0, 5'd0, 1'b1, 1'b0});

    // Full program of load-immediates, then an attempted 17th word.
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    @(negedge clk);
    check("full_state", {26'd0, bus.in_ready, word_cnt}, {26'd0, 1'b0, 5'd16});
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check("overflow_refused", {26'd0, bus.in_ready, word_cnt}, {26'd0, 1'b0, 5'd16});
    end
    bus.in_valid = 1'b0;
    start_burst();
    check_burst("full16");

    // start is ignored in RUN.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("run_ignores_start", {29'd0, running, mem_write, pc_reset}, 32'b100);
    end
    do_reload();

    // Short program padded with halt words.
    push(8'h65);
    push(8'h70);
    push(8'h9F);
    start_burst();
    check_burst("short3");
    do_reload();

    // start in the same cycle as the second handshake.
    push(8'h31);
    push_with_start(8'h42);
    check_burst("same_cycle");
    do_reload();

    // Reset on the 7th burst cycle, then a fresh load.
    for (int i = 0; i < 5; i++) push(8'($urandom));
    start_burst();
    repeat (7) begin
      @(negedge clk);
      check("pre_reset_mw", {31'd0, mem_write}, 32'd1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    prog.delete();
    @(negedge clk);
    check("midburst_reset", {23'd0, pc_reset, mem_write, word_cnt, bus.in_ready, running},
          {23'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0});
    for (int i = 0; i < 7; i++) push(8'($urandom));
    start_burst();
    check_burst("after_reset");
    do_reload();

    // Randomized programs, including empty and full ones.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(0, 16);
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n - 1; i++) push(8'($urandom));
        push_with_start(8'($urandom));
      end else begin
        for (int i = 0; i < n; i++) push(8'($urandom));
        start_burst();
      end
      check_burst("random");
      do_reload();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the 4-bit processor core. Buffers a program arriving as a stream of 8-bit words (opcode[7:4], operand[3:0]) over a valid/ready handshake.
- On command, bursts the buffered program into the core's program memory by driving the core's PC_reset, mem_write, instr and portin pins, then rewinds the core's PC and releases the core to run.
- Holds the core in reset while filling, so the core never executes a partially loaded program.

Parameters:
- DEPTH, 16, program memory words; must equal 2^ADDR_W.
- ADDR_W, 4, core PC width.
- PAD_WORD, 8'h9F, word written to every slot not supplied by the host (jump to 15, i.e. halt loop).

Ports:
- clk  in  1  system clock; the core samples on the rising edge and advances its PC on the falling edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host word valid.
- in_data  in  8  host word, [7:4] opcode, [3:0] operand/address.
- in_ready  out  1  loader accepts a word this cycle.
- start  in  1  begin burst; sampled only in FILL.
- reload  in  1  return to FILL; sampled only in RUN.
- pc_reset  out  1  drives core PC_reset.
- mem_write  out  1  drives core mem_write.
- instr  out  4  drives core instr (word[7:4]).
- portin  out  4  drives core portin (word[3:0]).
- word_cnt  out  5  number of words buffered, 0..DEPTH.
- running  out  1  high in RUN.

Behaviour:
- All outputs are registered. Buffer: DEPTH x 8 storage, write pointer equal to word_cnt.
- States: FILL, BURST, REWIND, RUN.
- Reset (any state, including mid-burst): state FILL, word_cnt=0, pc_reset=1, mem_write=0, instr=0, portin=0, running=0. Buffer contents are not cleared; slots at or above word_cnt are padded on emission.
- FILL:
  - pc_reset=1, mem_write=0, in_ready = (word_cnt < DEPTH).
  - A handshake (in_valid & in_ready at the rising edge) stores in_data at buf[word_cnt] and increments word_cnt.
  - With word_cnt = DEPTH, in_ready=0 and further words are not taken.
  - start=1 goes to BURST. A same-cycle handshake is accepted and counted before the burst.
- BURST contract with the core:
  - After PC_reset falls, the core PC advances on the falling edge before the first write. The e-th emitted word (e = 0..DEPTH-1) therefore lands at address (e+1) mod DEPTH.
  - The loader emits slot s = (e+1) mod DEPTH on cycle e, i.e. order 1,2,...,DEPTH-1,0.
  - In BURST: pc_reset=0, mem_write=1, in_ready=0, {instr,portin} = buf[s] if s < word_cnt, else PAD_WORD.
  - The first emitted word appears on the cycle after start is sampled.
  - Exactly DEPTH cycles, one word per cycle, with no gaps; a gap would skip a PC slot.
  - Internal emit counter is ADDR_W+1 bits.
- REWIND: one cycle with pc_reset=1, mem_write=0, instr=portin=0, so the core PC returns to 0.
- RUN:
  - pc_reset=0, mem_write=0, running=1, in_ready=0.
  - reload=1 goes to FILL with word_cnt=0 and pc_reset=1 on the next cycle.
- start outside FILL and reload outside RUN are ignored. start with word_cnt=0 loads a program made entirely of PAD_WORD.
- word_cnt holds its value through BURST, REWIND and RUN, and clears only on reset or reload.

Test Plan:
- Reset, push 16 words 0x60..0x6F (load-immediate 0..15), then start -> in_ready low after the 16th word. mem_write is high for exactly 16 cycles emitting 0x61,0x62,...,0x6F,0x60. Then one pc_reset cycle, then running=1. Core PM[a] = 0x60+a for all a.
- Push 3 words {0x65,0x70,0x9F}, then start -> emitted order 0x70,0x9F,then PAD 0x9F x13, then 0x65 last. Core program outputs 5 on portout, then halts at address 15.
- in_valid held with start asserted in the same cycle as the 2nd word -> word_cnt=2 and the 2nd word is included in the burst.
- Assert reset on the 7th BURST cycle -> next cycle pc_reset=1, mem_write=0, word_cnt=0, state FILL. A fresh load then completes normally.
- In RUN, pulse start (ignored, no burst), then pulse reload -> pc_reset=1 next cycle, word_cnt=0, in_ready=1. A second program loads and runs correctly.
- Try to push a 17th word while word_cnt=16 -> in_ready=0, word_cnt stays 16, buffer unchanged.
